// File: rtl/atm_controller.sv
// ATM engine: authenticates acct/PIN, then runs balance/withdraw/deposit/PIN-change on a small account table.
// Latency 4 posedges per transaction; no backpressure, host holds inputs stable for the whole transaction.
module atm_controller #(
    parameter int NUM_ACCTS = 10,
    parameter int BAL_W     = 32,
    parameter int PIN_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       operation,
    input  logic [3:0]       acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic [PIN_W-1:0] newPin,
    input  logic [BAL_W-1:0] amount,
    input  logic             language,
    output logic [BAL_W-1:0] balance,
    output logic             success,
    output logic [2:0]       state
);
    typedef enum logic [2:0] {
        ACC_CHECK = 3'd0,
        PIN_CHECK = 3'd1,
        MENU      = 3'd2,
        BAL_OP    = 3'd3,
        WDR_OP    = 3'd4,
        DEP_OP    = 3'd5,
        CHG_OP    = 3'd6,
        IDLE      = 3'd7
    } state_t;

    localparam int         IDX_W   = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;
    localparam logic [3:0] MAX_ACC = 4'(NUM_ACCTS);

    function automatic logic [PIN_W-1:0] default_pin(input int k);
        case (k)
            0:       default_pin = PIN_W'(1234);
            1:       default_pin = PIN_W'(2345);
            2:       default_pin = PIN_W'(3456);
            3:       default_pin = PIN_W'(4567);
            4:       default_pin = PIN_W'(5678);
            5:       default_pin = PIN_W'(6789);
            6:       default_pin = PIN_W'(7890);
            7:       default_pin = PIN_W'(8901);
            8:       default_pin = PIN_W'(9012);
            9:       default_pin = PIN_W'(7123);
            default: default_pin = '0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic             success_q, success_d;
    logic [PIN_W-1:0] pin_q [NUM_ACCTS];
    logic [PIN_W-1:0] pin_d [NUM_ACCTS];
    logic [BAL_W-1:0] bal_q [NUM_ACCTS];
    logic [BAL_W-1:0] bal_d [NUM_ACCTS];

    logic             acct_ok;
    logic [IDX_W-1:0] acct_idx;
    logic [BAL_W-1:0] cur_bal;
    logic [PIN_W-1:0] cur_pin;
    logic [BAL_W:0]   dep_sum;
    logic             unused_lang;

    // Display language is host-side text only; it never affects the datapath.
    assign unused_lang = language;

    assign acct_ok  = (acc_num != 4'd0) && (acc_num <= MAX_ACC);
    assign acct_idx = IDX_W'(acc_num - 4'd1);
    assign cur_bal  = acct_ok ? bal_q[acct_idx] : '0;
    assign cur_pin  = acct_ok ? pin_q[acct_idx] : '0;
    assign dep_sum  = {1'b0, cur_bal} + {1'b0, amount};

    always_comb begin
        state_d   = state_q;
        balance_d = balance_q;
        success_d = success_q;
        pin_d     = pin_q;
        bal_d     = bal_q;
        case (state_q)
            IDLE: state_d = ACC_CHECK;
            ACC_CHECK: begin
                if (acct_ok) begin
                    state_d = PIN_CHECK;
                end else begin
                    success_d = 1'b0;
                    balance_d = '0;
                end
            end
            PIN_CHECK: begin
                if (acct_ok && (pin == cur_pin)) begin
                    state_d = MENU;
                end else begin
                    state_d   = ACC_CHECK;
                    success_d = 1'b0;
                    balance_d = '0;
                end
            end
            MENU: begin
                state_d   = ACC_CHECK;
                success_d = 1'b0;
                // acct_ok is re-qualified here so a host changing acc_num mid-flight cannot write out of range.
                if (acct_ok) begin
                    case (operation)
                        3'd3: begin
                            state_d   = BAL_OP;
                            balance_d = cur_bal;
                            success_d = 1'b1;
                        end
                        3'd4: begin
                            state_d   = WDR_OP;
                            balance_d = cur_bal;
                            if (amount <= cur_bal) begin
                                bal_d[acct_idx] = cur_bal - amount;
                                balance_d       = cur_bal - amount;
                                success_d       = 1'b1;
                            end
                        end
                        3'd5: begin
                            state_d   = DEP_OP;
                            balance_d = cur_bal;
                            if (!dep_sum[BAL_W]) begin
                                bal_d[acct_idx] = dep_sum[BAL_W-1:0];
                                balance_d       = dep_sum[BAL_W-1:0];
                                success_d       = 1'b1;
                            end
                        end
                        3'd6: begin
                            state_d   = CHG_OP;
                            balance_d = cur_bal;
                            if (newPin != cur_pin) begin
                                pin_d[acct_idx] = newPin;
                                success_d       = 1'b1;
                            end
                        end
                        default: state_d = ACC_CHECK;
                    endcase
                end
            end
            BAL_OP, WDR_OP, DEP_OP, CHG_OP: state_d = ACC_CHECK;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            balance_q <= '0;
            success_q <= 1'b0;
            for (int i = 0; i < NUM_ACCTS; i++) begin
                pin_q[i] <= default_pin(i);
                bal_q[i] <= BAL_W'(1000 * (i + 1));
            end
        end else begin
            state_q   <= state_d;
            balance_q <= balance_d;
            success_q <= success_d;
            pin_q     <= pin_d;
            bal_q     <= bal_d;
        end
    end

    assign balance = balance_q;
    assign success = success_q;
    assign state   = state_q;
endmodule

// File: tb/tb_atm_controller.sv
// Directed and randomized transactions checked against an account-table reference model.
module tb_atm_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  operation;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] new_pin;
    logic [31:0] amount;
    logic        language;
    logic [31:0] balance;
    logic        success;
    logic [2:0]  state;

    always #5 clk = ~clk;

    atm_controller dut (
        .clk(clk), .rst(rst), .operation(operation), .acc_num(acc_num),
        .pin(pin), .newPin(new_pin), .amount(amount), .language(language),
        .balance(balance), .success(success), .state(state)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int def_pin [10] = '{1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 7123};
    logic [15:0] m_pin [1:10];
    logic [31:0] m_bal [1:10];
    logic [31:0] last_bal;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 1; k <= 10; k++) begin
            m_pin[k] = 16'(def_pin[k-1]);
            m_bal[k] = 32'(1000 * k);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_state", 32'(state), 32'd7);
        check("rst_balance", balance, 32'd0);
        check("rst_success", 32'(success), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_txn(input int op, input int acc, input int p, input int np, input logic [31:0] amt);
        operation = 3'(op);
        acc_num   = 4'(acc);
        pin       = 16'(p);
        new_pin   = 16'(np);
        amount    = amt;
        language  = 1'($urandom_range(0, 1));
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Reference: the rules of each operation applied to the model table.
    task automatic valid_txn(input string tag, input int op, input int acc, input int np, input logic [31:0] amt);
        logic [31:0] eb;
        logic        es;
        run_txn(op, acc, int'(m_pin[acc]), np, amt);
        es = 1'b0;
        case (op)
            3: es = 1'b1;
            4: if (amt <= m_bal[acc]) begin m_bal[acc] = m_bal[acc] - amt; es = 1'b1; end
            5: if (longint'(m_bal[acc]) + longint'(amt) <= 64'hFFFF_FFFF) begin
                   m_bal[acc] = m_bal[acc] + amt; es = 1'b1;
               end
            6: if (16'(np) != m_pin[acc]) begin m_pin[acc] = 16'(np); es = 1'b1; end
            default: es = 1'b0;
        endcase
        eb = m_bal[acc];
        check({tag, "_balance"}, balance, eb);
        check({tag, "_success"}, 32'(success), 32'(es));
        check({tag, "_state"}, 32'(state), 32'(op));
        last_bal = eb;
    endtask

    task automatic fail_txn(input string tag, input int op, input int acc, input int p, input logic [31:0] exp_bal);
        run_txn(op, acc, p, 0, 32'd0);
        check({tag, "_balance"}, balance, exp_bal);
        check({tag, "_success"}, 32'(success), 32'd0);
    endtask

    initial begin
        int st_exp [4] = '{0, 1, 2, 3};
        rst = 1'b1;
        operation = 3'd3; acc_num = 4'd1; pin = 16'd1234; new_pin = 16'd0;
        amount = 32'd0; language = 1'b0;
        #2;
        check("rst_state", 32'(state), 32'd7);
        check("rst_balance", balance, 32'd0);
        check("rst_success", 32'(success), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("seq_state%0d", i), 32'(state), 32'(st_exp[i]));
        end
        check("seq_balance", balance, 32'd1000);
        check("seq_success", 32'(success), 32'd1);

        for (int k = 1; k <= 10; k++) valid_txn($sformatf("query%0d", k), 3, k, 0, 32'd0);

        valid_txn("wdr_over", 4, 2, 0, 32'd2100);
        valid_txn("dep_1000", 5, 2, 0, 32'd1000);
        valid_txn("wdr_500", 4, 2, 0, 32'd500);
        valid_txn("wdr_zero", 4, 5, 0, 32'd0);
        valid_txn("wdr_all", 4, 4, 0, 32'd4000);
        valid_txn("dep_ovf", 5, 6, 0, 32'hFFFF_FFFF);
        valid_txn("dep_max", 5, 7, 0, 32'hFFFF_FFFF - 32'd7000);

        valid_txn("chg_same", 6, 1, 1234, 32'd0);
        valid_txn("chg_new", 6, 1, 5678, 32'd0);
        valid_txn("newpin_ok", 3, 1, 0, 32'd0);
        fail_txn("oldpin_bad", 3, 1, 1234, 32'd0);
        do_reset();

        valid_txn("pre_wrongpin", 3, 3, 0, 32'd0);
        fail_txn("wrong_pin", 3, 1, 7123, 32'd0);
        do_reset();
        valid_txn("pre_acc0", 3, 3, 0, 32'd0);
        fail_txn("acc0", 3, 0, 1234, 32'd0);
        check("acc0_state", 32'(state), 32'd0);
        do_reset();
        valid_txn("pre_acc11", 3, 3, 0, 32'd0);
        fail_txn("acc11", 3, 11, 1234, 32'd0);
        do_reset();

        valid_txn("pre_badop", 3, 8, 0, 32'd0);
        fail_txn("bad_op", 7, 8, 8901, last_bal);
        check("bad_op_state", 32'(state), 32'd0);
        do_reset();

        operation = 3'd4; acc_num = 4'd3; pin = 16'd3456; amount = 32'd500;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("abort_state", 32'(state), 32'd7);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        valid_txn("abort_query", 3, 3, 0, 32'd0);

        for (int i = 0; i < 40; i++) begin
            valid_txn($sformatf("rnd%0d", i), int'($urandom_range(3, 6)), int'($urandom_range(1, 10)),
                      int'($urandom_range(1000, 9999)), 32'($urandom_range(0, 10000)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
